rx_uart: RTL and testbench
==========================

RX_UART -- requirements
Module: rx_uart

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 9600, serial bit rate.
REQ-003 Parameter TICK_COUNT, default CLK_FREQ/(BAUD_RATE*16) truncated (325), clk cycles per 16x oversample tick; overridable for simulation.
REQ-004 clk  input  1  system clock, all state on rising edge; one clock domain only.
REQ-005 rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 rxData  input  1  asynchronous RS-232 serial line, idle high.
REQ-007 full  input  1  downstream FIFO full flag.
REQ-008 din  output  8  received byte presented to the FIFO write port.
REQ-009 wrEn  output  1  FIFO write strobe, one clk wide.
REQ-010 frameErr  output  1  one-clk pulse when the stop bit is sampled low.
REQ-011 overflow  output  1  one-clk pulse when a valid byte is dropped because full=1.

Function
REQ-012 rxData SHALL pass through a 2-flop synchronizer; all logic uses the synchronized value (rxS), reset value 1.
REQ-013 A tick counter SHALL count 0..TICK_COUNT-1 and assert a one-clk tick on wrap; it free-runs in all states except IDLE, where it is held at 0.
REQ-014 Oversample counter osCnt (4 bits) SHALL advance on each tick and be cleared on every state entry.
REQ-015 States: IDLE, START, DATA, STOP, WAIT_HIGH; encoded in 3 bits.
REQ-016 IDLE: on rxS=0 go to START (start-edge detection latency = 2 clk of synchronizer + 1 clk).
REQ-017 START: on the 8th tick (mid start bit) sample rxS; 0 -> DATA with bit index 0; 1 -> IDLE (glitch rejected, nothing written, no error).
REQ-018 DATA: every 16th tick sample rxS into shift register, LSB first; after bit index 7 is sampled go to STOP.
REQ-019 STOP: on the 16th tick sample rxS; 1 and full=0 -> din<=byte, wrEn=1 for exactly one clk, go to IDLE.
REQ-020 STOP, rxS=1 and full=1: byte discarded, overflow=1 for one clk, wrEn stays 0, go to IDLE.
REQ-021 STOP, rxS=0: frameErr=1 for one clk, no write, go to WAIT_HIGH regardless of full.
REQ-022 WAIT_HIGH: remain until rxS=1 (covers break condition), then go to IDLE; no new start detected while low.
REQ-023 din SHALL hold the last written byte until the next successful write.
REQ-024 full SHALL be sampled only in the STOP decision cycle; full toggling elsewhere has no effect.
REQ-025 wrEn, frameErr, overflow are mutually exclusive; at most one asserted in any cycle.
REQ-026 Back-to-back frames: a start bit beginning immediately after the stop bit sample SHALL be received without loss.
REQ-027 Tolerance: frames with baud error up to +/-2% SHALL be received correctly.

Reset
REQ-028 rst=0 SHALL asynchronously force: state IDLE, synchronizer flops 1, all counters 0, shift register 0, din=8'h00, wrEn=0, frameErr=0, overflow=0.
REQ-029 Reset asserted mid-frame SHALL abort the frame without any write or error pulse; after release the block waits in IDLE for a fresh falling edge.
REQ-030 Release of rst SHALL take effect on the next rising clk; no output pulses in the release cycle.

Verification (TICK_COUNT=4, bit period 64 clk)
REQ-031 Send 8'hA5 with stop=1, full=0 -> exactly one wrEn pulse, din=8'hA5, frameErr=overflow=0.
REQ-032 Send 8'h3C then 8'hC3 with no idle gap -> two wrEn pulses, din 8'h3C then 8'hC3.
REQ-033 Drive rxData low for 16 clk then high -> no wrEn, no frameErr, state returns to IDLE.
REQ-034 Send 8'h55 with stop bit 0, then hold line low 200 clk, then high, then send 8'h0F -> one frameErr pulse, no write for 8'h55, one wrEn with din=8'h0F.
REQ-035 Send 8'hFF with full=1 through the stop sample -> one overflow pulse, no wrEn, din unchanged (8'h00 after reset).
REQ-036 Assert rst=0 during data bit 4 of 8'h81, release, send 8'h42 -> no pulses for the aborted frame; one wrEn with din=8'h42.

Source files
------------

// File: rtl/rx_uart.sv
// UART receiver: 16x oversampling, 8N1 framing, writes each good byte into a downstream FIFO.
// Reports framing errors, and bytes dropped because the FIFO was full, as one-cycle pulses.
module rx_uart #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int TICK_COUNT = CLK_FREQ / (BAUD_RATE * 16)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxData,
  input  logic       full,
  output logic [7:0] din,
  output logic       wrEn,
  output logic       frameErr,
  output logic       overflow
);

  localparam int TickW = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } RxState;

  RxState           state, stateNext;
  logic             rxMeta, rxS;
  logic [TickW-1:0] tickCnt;
  logic             tick;
  logic [3:0]       osCnt;
  logic [2:0]       bitIdx;
  logic [7:0]       shiftReg;
  logic             doShift, writeNow, ferrNow, ovfNow;

  // The serial line is asynchronous, so it is resynchronised before any decision uses it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxMeta <= 1'b1;
      rxS    <= 1'b1;
    end else begin
      rxMeta <= rxData;
      rxS    <= rxMeta;
    end
  end

  assign tick = (state != IDLE) && (tickCnt == TickW'(TICK_COUNT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tickCnt <= '0;
    end else if (state == IDLE || tick) begin
      tickCnt <= '0;
    end else begin
      tickCnt <= tickCnt + 1'b1;
    end
  end

  // osCnt restarts on every state change so each state measures its own sample point.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      osCnt <= '0;
    end else if (stateNext != state) begin
      osCnt <= '0;
    end else if (tick) begin
      osCnt <= osCnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    doShift   = 1'b0;
    writeNow  = 1'b0;
    ferrNow   = 1'b0;
    ovfNow    = 1'b0;
    case (state)
      IDLE: begin
        if (!rxS) stateNext = START;
      end
      START: begin
        if (tick && osCnt == 4'd7) stateNext = rxS ? IDLE : DATA;
      end
      DATA: begin
        if (tick && osCnt == 4'd15) begin
          doShift = 1'b1;
          if (bitIdx == 3'd7) stateNext = STOP;
        end
      end
      STOP: begin
        if (tick && osCnt == 4'd15) begin
          if (!rxS) begin
            ferrNow   = 1'b1;
            stateNext = WAIT_HIGH;
          end else begin
            writeNow  = !full;
            ovfNow    = full;
            stateNext = IDLE;
          end
        end
      end
      WAIT_HIGH: begin
        if (rxS) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Data arrives LSB first, so each new bit enters at the top and shifts down.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shiftReg <= '0;
      bitIdx   <= '0;
    end else begin
      if (doShift) shiftReg <= {rxS, shiftReg[7:1]};
      if (state != DATA) begin
        bitIdx <= '0;
      end else if (doShift) begin
        bitIdx <= bitIdx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      din      <= 8'h00;
      wrEn     <= 1'b0;
      frameErr <= 1'b0;
      overflow <= 1'b0;
    end else begin
      wrEn     <= writeNow;
      frameErr <= ferrNow;
      overflow <= ovfNow;
      if (writeNow) din <= shiftReg;
    end
  end

endmodule

// File: tb/tb_rx_uart.sv
// Self-checking bench for rx_uart: directed frames plus randomized frames with baud skew,
// checked every cycle against a frame-level outcome queue.
module tb_rx_uart;

  localparam int TC  = 4;
  localparam int BIT = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxData = 1'b1;
  logic       full = 1'b0;
  logic [7:0] din;
  logic       wrEn, frameErr, overflow;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } ExpEvent;

  ExpEvent    expQ[$];
  ExpEvent    headEv;
  logic [7:0] modelDin = 8'h00;
  int         compared = 0;
  int         mismatched = 0;
  int         wrCnt = 0, ferrCnt = 0, ovfCnt = 0;
  int         pulseKind, pulses;
  int         w0, f0, o0;

  always #5 clk = ~clk;

  rx_uart #(
    .CLK_FREQ(50_000_000),
    .BAUD_RATE(9600),
    .TICK_COUNT(TC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rxData(rxData),
    .full(full),
    .din(din),
    .wrEn(wrEn),
    .frameErr(frameErr),
    .overflow(overflow)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every frame has one predicted outcome; each pulse must match the oldest outstanding one.
  always @(negedge clk) begin
    if (!rst) begin
      expQ.delete();
      modelDin = 8'h00;
      checkOutput("resetOutputs", 32'({din, wrEn, frameErr, overflow}), 32'd0);
    end else begin
      pulses = int'(wrEn) + int'(frameErr) + int'(overflow);
      checkOutput("exclusive", (pulses <= 1) ? 32'd1 : 32'd0, 32'd1);
      if (pulses != 0) begin
        pulseKind = wrEn ? 0 : (frameErr ? 1 : 2);
        if (wrEn) wrCnt++;
        if (frameErr) ferrCnt++;
        if (overflow) ovfCnt++;
        if (expQ.size() == 0) begin
          checkOutput("unexpectedPulse", 32'(pulseKind), 32'hFF);
        end else begin
          headEv = expQ.pop_front();
          checkOutput("pulseKind", 32'(pulseKind), 32'(headEv.kind));
          if (headEv.kind == 0) modelDin = headEv.data;
        end
      end
      checkOutput("din", 32'(din), 32'(modelDin));
    end
  end

  task automatic idle(input int n);
    rxData = 1'b1;
    repeat (n) @(posedge clk);
  endtask

  // abortBit >= 0 resets the DUT in the middle of that data bit and ends the frame there.
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input logic fullAtStop,
                               input int period, input bit toggleFull, input int abortBit);
    ExpEvent e;
    logic    b;
    if (abortBit < 0) begin
      e.kind = !stopBit ? 1 : (fullAtStop ? 2 : 0);
      e.data = data;
      expQ.push_back(e);
    end
    for (int i = 0; i < 10; i++) begin
      b = (i == 0) ? 1'b0 : ((i == 9) ? stopBit : data[i-1]);
      if (i == 9) full = fullAtStop;
      else if (toggleFull) full = 1'($urandom_range(0, 1));
      rxData = b;
      if (abortBit >= 0 && i == abortBit + 1) begin
        repeat (period / 2) @(posedge clk);
        rst = 1'b0;
        rxData = 1'b1;
        repeat (5) @(posedge clk);
        rst = 1'b1;
        return;
      end
      repeat (period) @(posedge clk);
    end
  endtask

  task automatic checkDrained(input string name);
    int waited = 0;
    while (expQ.size() != 0 && waited < 300) begin
      @(posedge clk);
      waited++;
    end
    checkOutput(name, 32'(expQ.size()), 32'd0);
  endtask

  task automatic snapCounts();
    w0 = wrCnt;
    f0 = ferrCnt;
    o0 = ovfCnt;
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] d;
    logic       sb, fs;
    int         per;
    rst = 1'b0;
    rxData = 1'b1;
    full = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("resetDin", 32'(din), 32'h00);
    checkOutput("resetWrEn", 32'(wrEn), 32'd0);
    @(posedge clk);
    rst = 1'b1;
    idle(10);

    // Full FIFO at the stop sample: dropped byte, din keeps its reset value.
    snapCounts();
    applyStimulus(8'hFF, 1'b1, 1'b1, BIT, 1'b0, -1);
    idle(10);
    full = 1'b0;
    checkDrained("drainOvf");
    checkOutput("ovfDin", 32'(din), 32'h00);
    checkOutput("ovfCount", 32'(ovfCnt - o0), 32'd1);
    checkOutput("ovfNoWrite", 32'(wrCnt - w0), 32'd0);

    snapCounts();
    applyStimulus(8'hA5, 1'b1, 1'b0, BIT, 1'b0, -1);
    idle(10);
    checkDrained("drainA5");
    checkOutput("a5Din", 32'(din), 32'hA5);
    checkOutput("a5Writes", 32'(wrCnt - w0), 32'd1);
    checkOutput("a5Errors", 32'(ferrCnt - f0 + ovfCnt - o0), 32'd0);

    snapCounts();
    applyStimulus(8'h3C, 1'b1, 1'b0, BIT, 1'b0, -1);
    applyStimulus(8'hC3, 1'b1, 1'b0, BIT, 1'b0, -1);
    idle(10);
    checkDrained("drainB2B");
    checkOutput("b2bDin", 32'(din), 32'hC3);
    checkOutput("b2bWrites", 32'(wrCnt - w0), 32'd2);

    snapCounts();
    rxData = 1'b0;
    repeat (16) @(posedge clk);
    idle(100);
    checkOutput("glitchPulses", 32'(wrCnt - w0 + ferrCnt - f0 + ovfCnt - o0), 32'd0);

    snapCounts();
    applyStimulus(8'h55, 1'b0, 1'b0, BIT, 1'b0, -1);
    rxData = 1'b0;
    repeat (200) @(posedge clk);
    idle(BIT);
    applyStimulus(8'h0F, 1'b1, 1'b0, BIT, 1'b0, -1);
    idle(10);
    checkDrained("drainFerr");
    checkOutput("ferrCount", 32'(ferrCnt - f0), 32'd1);
    checkOutput("ferrWrites", 32'(wrCnt - w0), 32'd1);
    checkOutput("ferrDin", 32'(din), 32'h0F);

    snapCounts();
    applyStimulus(8'h81, 1'b1, 1'b0, BIT, 1'b0, 4);
    idle(BIT);
    applyStimulus(8'h42, 1'b1, 1'b0, BIT, 1'b0, -1);
    idle(10);
    checkDrained("drainAbort");
    checkOutput("abortWrites", 32'(wrCnt - w0), 32'd1);
    checkOutput("abortErrors", 32'(ferrCnt - f0 + ovfCnt - o0), 32'd0);
    checkOutput("abortDin", 32'(din), 32'h42);

    // Random frames with up to ~1.6% baud skew, random FIFO state and occasional glitches.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        rxData = 1'b0;
        repeat ($urandom_range(1, 20)) @(posedge clk);
        idle(80);
      end
      d   = 8'($urandom);
      sb  = ($urandom_range(0, 7) != 0);
      fs  = ($urandom_range(0, 3) == 0);
      per = $urandom_range(BIT - 1, BIT + 1);
      applyStimulus(d, sb, fs, per, bit'($urandom_range(0, 1)), -1);
      if (!sb) begin
        rxData = 1'b0;
        repeat ($urandom_range(0, 150)) @(posedge clk);
        idle(BIT);
      end else if ($urandom_range(0, 1) == 0) begin
        idle($urandom_range(0, 40));
      end
    end
    idle(20);
    full = 1'b0;
    checkDrained("drainRandom");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
